// File: rtl/descramble_multi.sv
// rtl/descramble_multi.sv - 802.11 x^7+x^4+1 descrambler with seed recovery, IN_WIDTH bits per beat
//
// Ports:
//   clock, rstn            rising-edge clock, synchronous active-low reset
//   enable                 low: strobes ignored, all state held
//   frame_start            pulse: restart seed acquisition for a new packet
//   seed_load, seed_in     load an explicit 7-bit seed and skip acquisition
//   in_data, input_strobe  scrambled bits (bit 0 earliest) and beat valid
//   out_data, output_strobe descrambled bits, one pulse per accepted beat, 1-cycle latency
//   seed_out, seed_valid   recovered/loaded seed and its valid level
//   service_err            sticky reserved-SERVICE-bit error (DESCRAMBLE_SERVICE_CHECK_EN only)
//
// Optional feature macro: DESCRAMBLE_SERVICE_CHECK_EN
module descramble_multi #(
    parameter int IN_WIDTH = 1
) (
    input  logic                clock,
    input  logic                rstn,
    input  logic                enable,
    input  logic                frame_start,
    input  logic                seed_load,
    input  logic [6:0]          seed_in,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                input_strobe,
    output logic [IN_WIDTH-1:0] out_data,
    output logic                output_strobe,
    output logic [6:0]          seed_out,
    output logic                seed_valid
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
    ,
    output logic                service_err
`endif
);

    generate
        if (IN_WIDTH != 1 && IN_WIDTH != 2 && IN_WIDTH != 4 && IN_WIDTH != 8) begin : g_width_check
            $error("descramble_multi: IN_WIDTH must be 1, 2, 4 or 8");
        end
    endgenerate

    // Frame bit counter only needs to reach the end of the region we inspect:
    // the reserved SERVICE bits end at 15 when checking, otherwise RUN starts at 7.
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
    localparam logic [4:0] BCNT_SAT = 5'd16;
`else
    localparam logic [4:0] BCNT_SAT = 5'd7;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [6:0]            lfsr_q, lfsr_d;
    logic [4:0]            bcnt_q, bcnt_d;
    logic [IN_WIDTH-1:0]   out_d;
    logic                  strobe_d;
    logic [6:0]            seed_d;
    logic                  valid_d;
    logic                  fb;
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
    logic                  err_q, err_d;
    logic                  chk_q, chk_d;    // check armed only for frames acquired through ACQ
`endif

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        bcnt_d   = bcnt_q;
        out_d    = out_data;
        strobe_d = 1'b0;
        seed_d   = seed_out;
        valid_d  = seed_valid;
        fb       = 1'b0;
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
        err_d    = err_q;
        chk_d    = chk_q;
`endif
        if (enable) begin
            if (frame_start) begin
                state_d = IDLE;
                bcnt_d  = 5'd0;
                seed_d  = 7'd0;
                valid_d = 1'b0;
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
                err_d   = 1'b0;
                chk_d   = 1'b1;
`endif
            end else if (seed_load) begin
                state_d = RUN;
                lfsr_d  = seed_in;
                seed_d  = seed_in;
                valid_d = 1'b1;
                bcnt_d  = 5'd7;
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
                chk_d   = 1'b0;
`endif
            end

            // The restart/load above is already folded into the working copies,
            // so a coincident beat sees the new frame position and seed.
            if (input_strobe) begin
                strobe_d = 1'b1;
                for (int i = 0; i < IN_WIDTH; i++) begin
                    if (bcnt_d < 5'd7) begin
                        // SERVICE bits are zero, so the scrambled bit is the LFSR bit itself.
                        lfsr_d[3'd6 - bcnt_d[2:0]] = in_data[i];
                        out_d[i] = 1'b0;
                        if (bcnt_d == 5'd6) begin
                            state_d = RUN;
                            seed_d  = lfsr_d;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ACQ;
                        end
                    end else begin
                        fb       = lfsr_d[6] ^ lfsr_d[3];
                        out_d[i] = fb ^ in_data[i];
                        lfsr_d   = {lfsr_d[5:0], fb};
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
                        if (chk_d && (bcnt_d < 5'd16) && out_d[i]) begin
                            err_d = 1'b1;
                        end
`endif
                    end
                    if (bcnt_d < BCNT_SAT) begin
                        bcnt_d = bcnt_d + 5'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q       <= IDLE;
            lfsr_q        <= 7'd0;
            bcnt_q        <= 5'd0;
            out_data      <= '0;
            output_strobe <= 1'b0;
            seed_out      <= 7'd0;
            seed_valid    <= 1'b0;
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
            err_q         <= 1'b0;
            chk_q         <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            bcnt_q        <= bcnt_d;
            out_data      <= out_d;
            output_strobe <= strobe_d;
            seed_out      <= seed_d;
            seed_valid    <= valid_d;
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
            err_q         <= err_d;
            chk_q         <= chk_d;
`endif
        end
    end

`ifdef DESCRAMBLE_SERVICE_CHECK_EN
    assign service_err = err_q;
`endif

endmodule

// File: tb/tb_descramble_multi.sv
// tb/tb_descramble_multi.sv - self-checking bench for descramble_multi (IN_WIDTH 1 and 8)
module tb_descramble_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       en1, fs1, sl1, st1, os1, sv1;
    logic [6:0] si1, so1;
    logic [0:0] d1, od1;
    logic       en8, fs8, sl8, st8, os8, sv8;
    logic [6:0] si8, so8;
    logic [7:0] d8, od8;
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
    logic       err1, err8;
`endif

    descramble_multi #(.IN_WIDTH(1)) dut1 (
        .clock(clk), .rstn(rstn), .enable(en1), .frame_start(fs1), .seed_load(sl1),
        .seed_in(si1), .in_data(d1), .input_strobe(st1), .out_data(od1),
        .output_strobe(os1), .seed_out(so1), .seed_valid(sv1)
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
        , .service_err(err1)
`endif
    );

    descramble_multi #(.IN_WIDTH(8)) dut8 (
        .clock(clk), .rstn(rstn), .enable(en8), .frame_start(fs8), .seed_load(sl8),
        .seed_in(si8), .in_data(d8), .input_strobe(st8), .out_data(od8),
        .output_strobe(os8), .seed_out(so8), .seed_valid(sv8)
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
        , .service_err(err8)
`endif
    );

    typedef struct {
        logic [7:0] d;
        logic       sv;
        logic [6:0] so;
        logic       err;
    } exp_t;

    typedef struct {
        bit         w8;
        bit         load;
        bit         fs;
        logic [6:0] seed;
        logic [6:0] exp_seed;
        int         nbits;
        int         kind;      // 0 zero payload, 1 random after bit 15, 2 only bit 12 set
        int         stall;     // beat index preceded by 3 enable-low cycles, -1 none
        bit         drain;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl[NV];

    exp_t q1[$];
    exp_t q8[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt[2];
    int   acc[2];
    bit   sv_m[2];
    logic [6:0] so_m[2];
    bit   err_m[2];
    bit   chk_m[2];
    bit   pay[0:127];
    bit   scr[0:127];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (os1) begin
                cnt[0]++;
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL w1_strobe: got unexpected output_strobe, expected none at %0t", $time);
                end else begin
                    e = q1.pop_front();
                    chk("w1_out_data", 32'(od1), 32'(e.d[0]));
                    chk("w1_seed_valid", 32'(sv1), 32'(e.sv));
                    chk("w1_seed_out", 32'(so1), 32'(e.so));
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
                    chk("w1_service_err", 32'(err1), 32'(e.err));
`endif
                end
            end
            if (os8) begin
                cnt[1]++;
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL w8_strobe: got unexpected output_strobe, expected none at %0t", $time);
                end else begin
                    e = q8.pop_front();
                    chk("w8_out_data", 32'(od8), 32'(e.d));
                    chk("w8_seed_valid", 32'(sv8), 32'(e.sv));
                    chk("w8_seed_out", 32'(so8), 32'(e.so));
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
                    chk("w8_service_err", 32'(err8), 32'(e.err));
`endif
                end
            end
        end
    endtask

    // Scramble a payload with the transmitter LFSR, then stream it into the selected DUT,
    // pushing the expected descrambled beat and status for each accepted beat.
    task automatic run_frame(input vec_t v);
        logic [6:0] st;
        bit         fb, p;
        int         w, width, nbeats, n, k;
        exp_t       e;
        w     = v.w8 ? 1 : 0;
        width = v.w8 ? 8 : 1;
        st    = v.seed;
        for (int j = 0; j < v.nbits; j++) begin
            case (v.kind)
                1:       p = (j < 16) ? 1'b0 : 1'($urandom_range(0, 1));
                2:       p = (j == 12);
                default: p = 1'b0;
            endcase
            if (!v.load && j < 7) p = 1'b0;
            fb     = st[6] ^ st[3];
            st     = {st[5:0], fb};
            pay[j] = p;
            scr[j] = p ^ fb;
        end
        if (v.fs) begin
            sv_m[w]  = 1'b0;
            so_m[w]  = 7'd0;
            err_m[w] = 1'b0;
            chk_m[w] = 1'b1;
        end
        if (v.load) begin
            sv_m[w]  = 1'b1;
            so_m[w]  = v.seed;
            chk_m[w] = 1'b0;
        end
        nbeats = v.nbits / width;
        for (int b = 0; b < nbeats; b++) begin
            if (b == v.stall) begin
                if (v.w8) begin en8 = 1'b0; st8 = 1'b1; end
                else      begin en1 = 1'b0; st1 = 1'b1; end
                repeat (3) begin
                    d8 = 8'($urandom);
                    d1 = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                en1 = 1'b1;
                en8 = 1'b1;
            end
            e.d = '0;
            for (int i = 0; i < width; i++) begin
                n = b * width + i;
                k = v.load ? n + 7 : n;
                e.d[i] = pay[n];
                if (!v.load && n == 6) begin
                    sv_m[w] = 1'b1;
                    so_m[w] = v.exp_seed;
                end
                if (chk_m[w] && k >= 7 && k < 16 && pay[n]) err_m[w] = 1'b1;
            end
            e.sv  = sv_m[w];
            e.so  = so_m[w];
            e.err = err_m[w];
            if (v.w8) begin
                for (int i = 0; i < 8; i++) d8[i] = scr[b * 8 + i];
                st8 = 1'b1;
                fs8 = (b == 0) && v.fs;
                sl8 = (b == 0) && v.load;
                si8 = v.seed;
                q8.push_back(e);
            end else begin
                d1[0] = scr[b];
                st1 = 1'b1;
                fs1 = (b == 0) && v.fs;
                sl1 = (b == 0) && v.load;
                si1 = v.seed;
                q1.push_back(e);
            end
            @(posedge clk);
            #1;
            fs1 = 1'b0; sl1 = 1'b0; fs8 = 1'b0; sl8 = 1'b0;
        end
        st1 = 1'b0;
        st8 = 1'b0;
        acc[w] += nbeats;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        chk("w1_strobe_count", cnt[0], acc[0]);
        chk("w8_strobe_count", cnt[1], acc[1]);
        chk("w1_pending", q1.size(), 0);
        chk("w8_pending", q8.size(), 0);
    endtask

    task automatic clear_models();
        for (int w = 0; w < 2; w++) begin
            sv_m[w]  = 1'b0;
            so_m[w]  = 7'd0;
            err_m[w] = 1'b0;
            chk_m[w] = 1'b1;
        end
    endtask

    initial begin
        vec_t post;
        fork
            monitor();
        join_none

        //            w8    load  fs    seed   exp    bits kind stall drain
        tbl[0] = '{1'b0, 1'b0, 1'b1, 7'h7F, 7'h07, 64, 0, -1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 7'h01, 7'h09, 32, 1, -1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 7'h7F, 7'h07, 64, 0, -1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 7'h5D, 7'h5D, 64, 1, -1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 7'h5D, 7'h36, 64, 1,  3, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 7'h5D, 7'h5D, 16, 1, -1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 7'h7F, 7'h07, 32, 2, -1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 7'h01, 7'h01, 32, 2, -1, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 7'h01, 7'h09, 32, 1, -1, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 7'h01, 7'h01, 32, 2, -1, 1'b1};

        cnt = '{0, 0};
        acc = '{0, 0};
        clear_models();
        rstn = 1'b0;
        en1 = 1'b1; fs1 = 1'b0; sl1 = 1'b0; st1 = 1'b0; si1 = 7'd0; d1 = 1'b0;
        en8 = 1'b1; fs8 = 1'b0; sl8 = 1'b0; st8 = 1'b0; si8 = 7'd0; d8 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w1_out_data", 32'(od1), 0);
        chk("rst_w1_strobe", 32'(os1), 0);
        chk("rst_w1_seed_out", 32'(so1), 0);
        chk("rst_w1_seed_valid", 32'(sv1), 0);
        chk("rst_w8_out_data", 32'(od8), 0);
        chk("rst_w8_strobe", 32'(os8), 0);
        chk("rst_w8_seed_out", 32'(so8), 0);
        chk("rst_w8_seed_valid", 32'(sv8), 0);
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
        chk("rst_w8_service_err", 32'(err8), 0);
`endif
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < NV; t++) begin
            run_frame(tbl[t]);
            if (tbl[t].drain) drain();
        end

        // Reset mid-frame with a beat presented on the reset edge.
        post = '{1'b1, 1'b0, 1'b1, 7'h7F, 7'h07, 24, 0, -1, 1'b0};
        run_frame(post);
        rstn = 1'b0;
        st8  = 1'b1;
        d8   = 8'hA5;
        @(posedge clk);
        #1;
        chk("midrst_w8_strobe", 32'(os8), 0);
        chk("midrst_w8_out_data", 32'(od8), 0);
        chk("midrst_w8_seed_out", 32'(so8), 0);
        chk("midrst_w8_seed_valid", 32'(sv8), 0);
        chk("midrst_w1_out_data", 32'(od1), 0);
        chk("midrst_w1_seed_valid", 32'(sv1), 0);
`ifdef DESCRAMBLE_SERVICE_CHECK_EN
        chk("midrst_w8_service_err", 32'(err8), 0);
`endif
        rstn = 1'b1;
        st8  = 1'b0;
        clear_models();
        drain();

        // Acquisition straight out of reset without a frame_start.
        post = '{1'b1, 1'b0, 1'b0, 7'h7F, 7'h07, 32, 0, -1, 1'b1};
        run_frame(post);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
